// File: rtl/deaes_round_engine.sv
// Iterative AES inverse cipher: one decryption round per clock over a 128-bit block.
// Round keys are read combinationally from an external schedule addressed by rk_idx_o.
module deaes_round_engine #(
  parameter int unsigned NR = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] data_in_i,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rk_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_out_o
);

  localparam int unsigned BW = 128;
  localparam int unsigned IW = 4;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] st_q, st_d;
  logic [BW-1:0] data_out_q, data_out_d;
  logic [IW-1:0] rnd_q, rnd_d;
  logic [IW-1:0] rk_idx_q, rk_idx_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [BW-1:0] isr_w, isb_w, ark_w, imc_w;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[3'(i)]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); it also maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(a, a);
    acc = sq;
    for (int unsigned i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse affine transform followed by the field inverse
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    for (int unsigned i = 0; i < 8; i++)
      b[3'(i)] = a[3'(i + 2)] ^ a[3'(i + 5)] ^ a[3'(i + 7)];
    return gf_inv(b ^ 8'h05);
  endfunction

  function automatic logic [BW-1:0] inv_shift_rows(input logic [BW-1:0] s);
    logic [BW-1:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[BW-1-8*(r+4*c) -: 8] = s[BW-1-8*(r+4*((c+4-r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [BW-1:0] inv_sub_bytes(input logic [BW-1:0] s);
    logic [BW-1:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++)
      o[BW-1-8*i -: 8] = inv_sbox(s[BW-1-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [BW-1:0] inv_mix_columns(input logic [BW-1:0] s);
    logic [BW-1:0]   o;
    logic [3:0][7:0] a;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++)
        a[2'(r)] = s[BW-1-8*(r+4*c) -: 8];
      for (int unsigned r = 0; r < 4; r++)
        o[BW-1-8*(r+4*c) -: 8] = gf_mul(a[2'(r)],     8'h0e) ^ gf_mul(a[2'(r + 1)], 8'h0b) ^
                                 gf_mul(a[2'(r + 2)], 8'h0d) ^ gf_mul(a[2'(r + 3)], 8'h09);
    end
    return o;
  endfunction

  // Round datapath: AddRoundKey precedes InvMixColumns in the inverse cipher
  assign isr_w = inv_shift_rows(st_q);
  assign isb_w = inv_sub_bytes(isr_w);
  assign ark_w = isb_w ^ rk_i;
  assign imc_w = inv_mix_columns(ark_w);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      st_q        <= '0;
      data_out_q  <= '0;
      rnd_q       <= '0;
      rk_idx_q    <= IW'(NR);
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      data_out_q  <= data_out_d;
      rnd_q       <= rnd_d;
      rk_idx_q    <= rk_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    data_out_d  = data_out_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
    rk_idx_d    = IW'(NR);
    in_ready_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid_i && in_ready_q) begin
          st_d    = data_in_i ^ rk_i;
          rnd_d   = IW'(NR - 1);
          state_d = (NR > 1) ? S_ROUND : S_FINAL;
        end
      end
      S_ROUND: begin
        st_d  = imc_w;
        rnd_d = rnd_q - IW'(1);
        if (rnd_q == IW'(1)) state_d = S_FINAL;
      end
      S_FINAL: begin
        data_out_d  = ark_w;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Key index and ready are registered, so derive them from the state being entered
    if (state_d == S_ROUND)      rk_idx_d = rnd_d;
    else if (state_d == S_FINAL) rk_idx_d = '0;
    in_ready_d = (state_d == S_IDLE);
  end

  assign in_ready_o  = in_ready_q;
  assign rk_idx_o    = rk_idx_q;
  assign out_valid_o = out_valid_q;
  assign data_out_o  = data_out_q;

endmodule

// File: tb/tb_deaes_round_engine.sv
// Self-checking bench for deaes_round_engine: FIPS-197 C.1 decryption, key-index sequencing,
// backpressure, back-to-back blocks, mid-block reset and an exhaustive inverse S-box sweep.
`timescale 1ns/1ps
module tb_deaes_round_engine;

  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] data_in, rk, data_out;
  logic [3:0]   rk_idx;

  logic         v1_in_valid, v1_in_ready, v1_out_valid, v1_out_ready;
  logic [127:0] v1_data_in, v1_rk, v1_data_out;
  logic [3:0]   v1_rk_idx;

  logic [127:0] kmem    [0:15];
  logic [127:0] c1_keys [0:15];
  logic [7:0]   sbox    [0:255];
  logic [7:0]   isbox   [0:255];
  logic [127:0] sb[$];
  logic [127:0] sb1[$];
  int n_checks = 0;
  int n_pass   = 0;

  always_comb rk = kmem[rk_idx];
  assign v1_rk = '0;

  deaes_round_engine #(.NR(10)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .data_in_i(data_in), .rk_idx_o(rk_idx), .rk_i(rk), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .data_out_o(data_out)
  );

  // Single-round instance: with a zero key, data_out = InvSubBytes(InvShiftRows(ct))
  deaes_round_engine #(.NR(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v1_in_valid), .in_ready_o(v1_in_ready),
    .data_in_i(v1_data_in), .rk_idx_o(v1_rk_idx), .rk_i(v1_rk), .out_valid_o(v1_out_valid),
    .out_ready_i(v1_out_ready), .data_out_o(v1_data_out)
  );

  // Carry-less product followed by long-division reduction by 0x11B
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = m_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      c1_keys[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Byte-array reference of the 10-round inverse cipher
  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic use_c1);
    logic [7:0]   s [0:15];
    logic [7:0]   t [0:15];
    logic [7:0]   a [0:3];
    logic [127:0] k, o;
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8];
    for (int rnd = 10; rnd >= 0; rnd--) begin
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[r+4*c] = isbox[s[r+4*((c-r+4)%4)]];
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      k = use_c1 ? c1_keys[rnd] : 128'h0;
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
      if (rnd != 10 && rnd != 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[r+4*c];
          for (int r = 0; r < 4; r++)
            s[r+4*c] = m_mul(8'h0e, a[r]) ^ m_mul(8'h0b, a[(r+1)%4]) ^
                       m_mul(8'h0d, a[(r+2)%4]) ^ m_mul(8'h09, a[(r+3)%4]);
        end
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++;
    if (data_out !== 128'h0) $display("FAIL reset_data_out: got %h expected 0", data_out); else n_pass++;
    n_checks++;
    if (rk_idx !== 4'd10) $display("FAIL reset_rk_idx: got %0d expected 10", rk_idx); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || v1_in_ready !== 1'b1)
      $display("FAIL post_reset_in_ready: got %b/%b expected 1/1", in_ready, v1_in_ready);
    else n_pass++;
  endtask

  task automatic test_c1_latency();
    int cyc;
    logic [127:0] exp;
    for (int i = 0; i < 16; i++) kmem[i] = c1_keys[i];
    out_ready = 1'b0;
    data_in   = C1_CT;
    in_valid  = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL c1_accept_ready: got %b expected 1", in_ready); else n_pass++;
    sb.push_back(C1_PT);
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = '0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc !== 11) $display("FAIL c1_latency: out_valid in cycle %0d expected 11", cyc); else n_pass++;
    exp = sb.pop_front();
    n_checks++;
    if (data_out !== exp) $display("FAIL c1_plaintext: got %h expected %h", data_out, exp); else n_pass++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || data_out !== C1_PT || in_ready !== 1'b0)
        $display("FAIL hold_cycle_%0d: valid=%b ready=%b data=%h expected valid=1 ready=0 data=%h",
                 i, out_valid, in_ready, data_out, C1_PT);
      else n_pass++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL release_to_idle: valid=%b ready=%b expected 0/1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_rk_sequence();
    logic [127:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (rk_idx !== 4'd10) $display("FAIL idle_rk_idx_%0d: got %0d expected 10", i, rk_idx); else n_pass++;
    end
    data_in  = C1_CT;
    in_valid = 1'b1;
    sb.push_back(C1_PT);
    n_checks++;
    if (rk_idx !== 4'd10) $display("FAIL accept_rk_idx: got %0d expected 10", rk_idx); else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (rk_idx !== 4'(10 - k)) $display("FAIL rk_idx_cycle_%0d: got %0d expected %0d", k, rk_idx, 10 - k);
      else n_pass++;
    end
    @(negedge clk);
    exp = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || data_out !== exp)
      $display("FAIL rkseq_output: valid=%b data=%h expected 1/%h", out_valid, data_out, exp);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc, acc_n, out_n;
    int acc_cyc [0:1];
    logic pend;
    logic [127:0] exp;
    cyc = 0; acc_n = 0; out_n = 0; pend = 1'b0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    for (int i = 0; i < 16; i++) kmem[i] = c1_keys[i];
    out_ready = 1'b1;
    data_in   = C1_CT;
    in_valid  = 1'b1;
    while (out_n < 2 && cyc < 100) begin
      if (pend) begin
        pend = 1'b0;
        if (acc_n == 1) data_in = '0;
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        n_checks++;
        if (sb.size() == 0) $display("FAIL b2b_unexpected_output: data=%h with nothing pending", data_out);
        else begin
          exp = sb.pop_front();
          if (data_out !== exp) $display("FAIL b2b_block_%0d: got %h expected %h", out_n, data_out, exp);
          else n_pass++;
        end
        out_n++;
        if (out_n == 1) for (int i = 0; i < 16; i++) kmem[i] = '0;
      end
      if (in_valid && in_ready && acc_n < 2) begin
        sb.push_back(acc_n == 0 ? C1_PT : ref_decrypt(128'h0, 1'b0));
        acc_cyc[acc_n] = cyc;
        acc_n++;
        pend = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_n !== 2) $display("FAIL b2b_outputs: got %0d blocks expected 2", out_n); else n_pass++;
    n_checks++;
    if (acc_cyc[1] - acc_cyc[0] !== 12)
      $display("FAIL b2b_spacing: got %0d clocks expected 12", acc_cyc[1] - acc_cyc[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_round();
    int cyc;
    logic seen;
    logic [127:0] exp;
    for (int i = 0; i < 16; i++) kmem[i] = c1_keys[i];
    out_ready = 1'b1;
    data_in   = C1_CT;
    in_valid  = 1'b1;
    sb.push_back(C1_PT);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (cyc < 5) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (rk_idx !== 4'd5) $display("FAIL abort_at_rnd5: rk_idx=%0d expected 5", rk_idx); else n_pass++;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || data_out !== 128'h0 || in_ready !== 1'b0 || rk_idx !== 4'd10)
      $display("FAIL abort_state: valid=%b data=%h ready=%b rk_idx=%0d expected 0/0/0/10",
               out_valid, data_out, in_ready, rk_idx);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL abort_release_ready: got %b expected 1", in_ready); else n_pass++;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL abort_no_output: out_valid seen=%b expected 0", seen); else n_pass++;
    data_in  = C1_CT;
    in_valid = 1'b1;
    sb.push_back(C1_PT);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    exp = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || data_out !== exp)
      $display("FAIL abort_fresh_block: valid=%b data=%h expected 1/%h", out_valid, data_out, exp);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_inv_sub_bytes();
    logic [7:0]   spot_in  [0:2];
    logic [7:0]   spot_out [0:2];
    logic [127:0] ct, exp;
    int cyc;
    spot_in  = '{8'h00, 8'h63, 8'hff};
    spot_out = '{8'h52, 8'h00, 8'h7d};
    for (int n = 0; n < 19; n++) begin
      if (n < 3) begin
        ct  = {16{spot_in[n]}};
        exp = {16{spot_out[n]}};
      end else begin
        for (int j = 0; j < 16; j++) ct[127-8*j -: 8] = 8'((n - 3) * 16 + j);
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            exp[127-8*(r+4*c) -: 8] = isbox[ct[127-8*(r+4*((c+4-r)%4)) -: 8]];
      end
      v1_data_in  = ct;
      v1_in_valid = 1'b1;
      sb1.push_back(exp);
      @(negedge clk);
      v1_in_valid = 1'b0;
      cyc = 1;
      if (n == 0) begin
        n_checks++;
        if (v1_rk_idx !== 4'd0) $display("FAIL nr1_final_rk_idx: got %0d expected 0", v1_rk_idx); else n_pass++;
      end
      while (!v1_out_valid && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      exp = sb1.pop_front();
      n_checks++;
      if (v1_out_valid !== 1'b1 || v1_data_out !== exp)
        $display("FAIL inv_sbox_block_%0d: valid=%b got %h expected %h", n, v1_out_valid, v1_data_out, exp);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
    v1_in_valid = 1'b0; v1_out_ready = 1'b1; v1_data_in = '0;
    for (int i = 0; i < 16; i++) kmem[i] = '0;
    build_tables();
    expand_key(C1_KEY);
    test_reset();
    test_c1_latency();
    test_backpressure();
    test_rk_sequence();
    test_back_to_back();
    test_reset_mid_round();
    test_inv_sub_bytes();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
